// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: multi-cycle multiply/divide unit with private HI/LO registers.
// Optional feature macro: MDU_CANCEL_EN (Req aborts an in-flight operation).
module e_muldiv_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       MDUOp,
   input  logic             Start,
   input  logic             Req,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] MDUOut
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam int unsigned PROD_W     = 2 * WIDTH;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic [0:0]       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] hi_d, lo_d;

   logic [PROD_W-1:0] prod;
   logic [WIDTH-1:0]  quo, rem;
   logic              div_zero;

   // Arithmetic on the latched operands; result is only consumed on the commit edge.
   always_comb begin
      logic [PROD_W-1:0] ext_a, ext_b;
      logic              is_signed, neg_a, neg_b;
      logic [WIDTH-1:0]  ua, ub, ub_safe, q, r;
      is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
      ext_a = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      ext_b = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      // Low 2*WIDTH bits of the product are correct for both signednesses after extension.
      prod     = ext_a * ext_b;
      neg_a    = is_signed && a_q[WIDTH-1];
      neg_b    = is_signed && b_q[WIDTH-1];
      ua       = neg_a ? -a_q : a_q;
      ub       = neg_b ? -b_q : b_q;
      div_zero = (b_q == '0);
      ub_safe  = div_zero ? WIDTH'(1) : ub;
      q        = ua / ub_safe;
      r        = ua % ub_safe;
      // Magnitude division makes the most-negative / -1 case wrap to itself with zero remainder.
      quo      = (neg_a ^ neg_b) ? -q : q;
      rem      = neg_a ? -r : r;
   end

   // Next-state, counter, operand latch and HI/LO update decisions.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = HI;
      lo_d    = LO;
      case (state)
         S_IDLE: begin
            if (!Req) begin
               if (Start) begin
                  op_d    = MDUOp;
                  a_d     = A;
                  b_d     = B;
                  cnt_d   = ((MDUOp == OP_DIV) || (MDUOp == OP_DIVU)) ?
                            CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  state_d = S_RUN;
               end else if (MDUOp == OP_MTHI) begin
                  hi_d = A;
               end else if (MDUOp == OP_MTLO) begin
                  lo_d = A;
               end
            end
         end
         default: begin
`ifdef MDU_CANCEL_EN
            if (Req) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else
`endif
            if (cnt == CNT_W'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
                  hi_d = prod[PROD_W-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end else if (!div_zero) begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         HI    <= hi_d;
         LO    <= lo_d;
      end
   end

   assign Busy = (state == S_RUN);

   // HI/LO move-from read port.
   always_comb begin
      MDUOut = '0;
      if (MDUOp == OP_MFHI) MDUOut = HI;
      else if (MDUOp == OP_MFLO) MDUOut = LO;
   end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed self-checking bench for e_muldiv_unit (WIDTH 32, MULT 5, DIV 10).
module tb_e_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  MDUOp;
   logic        Start;
   logic        Req;
   logic [31:0] A, B;
   logic        Busy;
   logic [31:0] HI, LO, MDUOut;

   int n_checks = 0;
   int n_fail   = 0;

   e_muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start), .Req(Req),
      .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count sampled Busy cycles from the current cycle until Busy falls (bounded).
   task automatic count_busy(output int n);
      n = 0;
      while (Busy && n < 50) begin
         n++;
         tick();
      end
   endtask

   // Issue one MD op, wait for completion and check the busy length.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int cycles);
      int n;
      MDUOp = op; A = a; B = b; Start = 1'b1;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      count_busy(n);
      check_eq({tag, "_busy_cycles"}, 64'(n), 64'(cycles));
   endtask

   task automatic move(input logic [3:0] op, input logic [31:0] a, input logic req);
      MDUOp = op; A = a; Req = req;
      tick();
      MDUOp = 4'd0; Req = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1; MDUOp = '0; Start = 1'b0; Req = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_eq("reset_busy", 64'(Busy), 64'(0));
      check_eq("reset_hi", 64'(HI), 64'(0));
      check_eq("reset_lo", 64'(LO), 64'(0));

      // Signed multiply: -3 * 7 = -21.
      MDUOp = 4'd1; A = 32'hFFFF_FFFD; B = 32'd7; Start = 1'b1;
      tick();
      Start = 1'b0; MDUOp = 4'd5;
      #1 check_eq("mfhi_pre_update", 64'(MDUOut), 64'(0));
      MDUOp = 4'd0;
      count_busy(n);
      check_eq("mult_busy_cycles", 64'(n), 64'(5));
      check_eq("mult_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
      check_eq("mult_lo", 64'(LO), 64'h0000_0000_FFFF_FFEB);

      // Back-to-back unsigned multiply in the first idle cycle.
      run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
      check_eq("multu_hi", 64'(HI), 64'(1));
      check_eq("multu_lo", 64'(LO), 64'h0000_0000_FFFF_FFFE);

      run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
      check_eq("div_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
      check_eq("div_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);

      run_op("divu", 4'd4, 32'd7, 32'd2, 10);
      check_eq("divu_lo", 64'(LO), 64'(3));
      check_eq("divu_hi", 64'(HI), 64'(1));

      run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      check_eq("div_ovf_lo", 64'(LO), 64'h0000_0000_8000_0000);
      check_eq("div_ovf_hi", 64'(HI), 64'(0));

      // Divide by zero keeps HI/LO.
      move(4'd7, 32'h1234, 1'b0);
      move(4'd8, 32'h5678, 1'b0);
      check_eq("mthi", 64'(HI), 64'h1234);
      check_eq("mtlo", 64'(LO), 64'h5678);
      run_op("div0", 4'd3, 32'd99, 32'd0, 10);
      check_eq("div0_hi", 64'(HI), 64'h1234);
      check_eq("div0_lo", 64'(LO), 64'h5678);

      // Req suppresses a start.
      MDUOp = 4'd1; A = 32'd3; B = 32'd3; Start = 1'b1; Req = 1'b1;
      tick();
      Start = 1'b0; Req = 1'b0; MDUOp = 4'd0;
      check_eq("req_start_busy", 64'(Busy), 64'(0));
      tick();
      check_eq("req_start_hi", 64'(HI), 64'h1234);
      check_eq("req_start_lo", 64'(LO), 64'h5678);

      // Req suppresses a move.
      move(4'd7, 32'hAAAA, 1'b1);
      check_eq("req_mthi", 64'(HI), 64'h1234);

      MDUOp = 4'd5; #1 check_eq("mfhi", 64'(MDUOut), 64'h1234);
      MDUOp = 4'd6; #1 check_eq("mflo", 64'(MDUOut), 64'h5678);
      MDUOp = 4'd9; #1 check_eq("mdout_other", 64'(MDUOut), 64'(0));
      MDUOp = 4'd0;
      tick();

      // Asynchronous reset in RUN cycle 3.
      MDUOp = 4'd1; A = 32'd4; B = 32'd4; Start = 1'b1;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      tick();
      tick();
      check_eq("pre_reset_busy", 64'(Busy), 64'(1));
      reset = 1'b1;
      #2;
      check_eq("async_reset_busy", 64'(Busy), 64'(0));
      check_eq("async_reset_hi", 64'(HI), 64'(0));
      check_eq("async_reset_lo", 64'(LO), 64'(0));
      reset = 1'b0;
      tick();
      run_op("mult_after_reset", 4'd1, 32'd3, 32'd5, 5);
      check_eq("mult_after_reset_lo", 64'(LO), 64'(15));
      check_eq("mult_after_reset_hi", 64'(HI), 64'(0));

      // Req in RUN cycle 2 of a div (100 / 7 = 14 r 2).
      move(4'd7, 32'h1111, 1'b0);
      move(4'd8, 32'h2222, 1'b0);
      MDUOp = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      tick();
      Req = 1'b1;
      tick();
      Req = 1'b0;
`ifdef MDU_CANCEL_EN
      check_eq("cancel_busy", 64'(Busy), 64'(0));
      tick();
      check_eq("cancel_hi", 64'(HI), 64'h1111);
      check_eq("cancel_lo", 64'(LO), 64'h2222);
`else
      count_busy(n);
      check_eq("nocancel_rest_cycles", 64'(n), 64'(8));
      check_eq("nocancel_hi", 64'(HI), 64'(2));
      check_eq("nocancel_lo", 64'(LO), 64'(14));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
